// File: rtl/ysyx_25020047_pkg.sv
// Shared types and widths for the IFU/LSU memory arbiter.
package ysyx_25020047_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = XLEN / 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Request captured at accept and replayed onto the memory port.
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic              wen;
    logic [XLEN-1:0]   wdata;
    logic [MASK_W-1:0] wmask;
    owner_e            owner;
  } mem_req_t;

endpackage

// File: rtl/ysyx_25020047_mem_arbiter_if.sv
// Bundled requester and memory-side signals of the arbiter.
interface ysyx_25020047_mem_arbiter_if;
  import ysyx_25020047_pkg::*;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [XLEN-1:0]   ifu_addr;
  logic              ifu_resp_valid;
  logic [XLEN-1:0]   ifu_resp_data;
  logic              ifu_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [XLEN-1:0]   lsu_addr;
  logic              lsu_wen;
  logic [XLEN-1:0]   lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [XLEN-1:0]   lsu_resp_data;
  logic              lsu_resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_wen;
  logic [XLEN-1:0]   mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_data;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output busy
  );

  // Core and memory side.
  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  busy
  );

endinterface

// File: rtl/ysyx_25020047_arb_timer.sv
// Transaction age counter; hit_c flags the cycle in which the age reaches TIMEOUT.
module ysyx_25020047_arb_timer
  import ysyx_25020047_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit_c
);

  logic [CNT_W-1:0] count;

  // Age counter, cleared at accept and advanced while the request is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Counting the current cycle, the age equals TIMEOUT.
  assign hit_c = en && ((count + CNT_W'(1)) == CNT_W'(TIMEOUT));

endmodule

// File: rtl/ysyx_25020047_mem_arbiter.sv
// Two-master (IFU, LSU) single-slave memory arbiter with response timeout.
module ysyx_25020047_mem_arbiter
  import ysyx_25020047_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_25020047_mem_arbiter_if.slave   bus
);

  state_e          state, state_n;
  mem_req_t        req_q, req_n;
  logic [XLEN-1:0] resp_data_q, resp_data_n;
  logic            resp_err_q, resp_err_n;
  logic            cnt_clr, cnt_en, hit_c;
  logic            in_idle, in_resp;

  ysyx_25020047_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .hit_c (hit_c)
  );

  // State, latched request and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state       <= state_n;
      req_q       <= req_n;
      resp_data_q <= resp_data_n;
      resp_err_q  <= resp_err_n;
    end
  end

  // Next-state, request capture and response capture.
  always_comb begin
    state_n     = state;
    req_n       = req_q;
    resp_data_n = resp_data_q;
    resp_err_n  = resp_err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.lsu_req_valid) begin
          req_n.addr  = bus.lsu_addr;
          req_n.wen   = bus.lsu_wen;
          req_n.wdata = bus.lsu_wdata;
          req_n.wmask = bus.lsu_wen ? bus.lsu_wmask : '0;
          req_n.owner = OWN_LSU;
          cnt_clr     = 1'b1;
          state_n     = ST_REQ;
        end else if (bus.ifu_req_valid) begin
          req_n.addr  = bus.ifu_addr;
          req_n.wen   = 1'b0;
          req_n.wdata = '0;
          req_n.wmask = '0;
          req_n.owner = OWN_IFU;
          cnt_clr     = 1'b1;
          state_n     = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_en = 1'b1;
        if (bus.mem_req_ready && bus.mem_resp_valid) begin
          resp_data_n = req_q.wen ? '0 : bus.mem_resp_data;
          resp_err_n  = 1'b0;
          state_n     = ST_RESP;
        end else if (hit_c) begin
          resp_data_n = '0;
          resp_err_n  = 1'b1;
          state_n     = ST_RESP;
        end else if (bus.mem_req_ready) begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (bus.mem_resp_valid) begin
          resp_data_n = req_q.wen ? '0 : bus.mem_resp_data;
          resp_err_n  = 1'b0;
          state_n     = ST_RESP;
        end else if (hit_c) begin
          resp_data_n = '0;
          resp_err_n  = 1'b1;
          state_n     = ST_RESP;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign in_idle = (state == ST_IDLE) && !rst;
  assign in_resp = (state == ST_RESP);

  // Grant is decoded from state and LSU valid only.
  assign bus.lsu_req_ready = in_idle;
  assign bus.ifu_req_ready = in_idle && !bus.lsu_req_valid;

  assign bus.mem_req_valid = (state == ST_REQ);
  assign bus.mem_addr      = req_q.addr;
  assign bus.mem_wen       = req_q.wen;
  assign bus.mem_wdata     = req_q.wdata;
  assign bus.mem_wmask     = req_q.wmask;

  // Response is routed only to the owner; the other port stays quiet.
  assign bus.ifu_resp_valid = in_resp && (req_q.owner == OWN_IFU);
  assign bus.lsu_resp_valid = in_resp && (req_q.owner == OWN_LSU);
  assign bus.ifu_resp_data  = bus.ifu_resp_valid ? resp_data_q : '0;
  assign bus.lsu_resp_data  = bus.lsu_resp_valid ? resp_data_q : '0;
  assign bus.ifu_resp_err   = bus.ifu_resp_valid && resp_err_q;
  assign bus.lsu_resp_err   = bus.lsu_resp_valid && resp_err_q;

  assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// Directed bench for the memory arbiter: vector table plus multi-cycle sequences.
module tb_ysyx_25020047_mem_arbiter;

  localparam logic [31:0] IA = 32'h8000_0000;
  localparam logic [31:0] LA = 32'h8000_1000;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ysyx_25020047_mem_arbiter_if ia ();
  ysyx_25020047_mem_arbiter_if ib ();

  ysyx_25020047_mem_arbiter #(.TIMEOUT(255)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  ysyx_25020047_mem_arbiter #(.TIMEOUT(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ifu_v;
    logic        lsu_v;
    logic        lsu_wen;
    logic        mrdy;
    logic        mrsp;
    logic [31:0] mdata;
    logic        e_ifu_rdy;
    logic        e_lsu_rdy;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [3:0]  e_wmask;
    logic        e_ifu_rv;
    logic        e_lsu_rv;
    logic [31:0] e_rdata;
    logic        e_busy;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ia.ifu_req_valid = 1'b0; ia.ifu_addr = IA;
    ia.lsu_req_valid = 1'b0; ia.lsu_addr = LA; ia.lsu_wen = 1'b0;
    ia.lsu_wdata = WD; ia.lsu_wmask = 4'hF;
    ia.mem_req_ready = 1'b0; ia.mem_resp_valid = 1'b0; ia.mem_resp_data = 32'h0;
    ib.ifu_req_valid = 1'b0; ib.ifu_addr = IA;
    ib.lsu_req_valid = 1'b0; ib.lsu_addr = LA; ib.lsu_wen = 1'b0;
    ib.lsu_wdata = WD; ib.lsu_wmask = 4'hF;
    ib.mem_req_ready = 1'b0; ib.mem_resp_valid = 1'b0; ib.mem_resp_data = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();

    //             ifu  lsu  wen  rdy  rsp  mdata          irdy lrdy mreq addr wen  wmask iRv  lRv  rdata          busy
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,1'b0,4'h0,1'b0,1'b0,32'h0,         1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,1'b0,4'h0,1'b0,1'b0,32'h0,         1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_0413, 1'b0,1'b0,1'b1,IA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b1};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,IA,   1'b0,4'h0,1'b1,1'b0,32'h0000_0413, 1'b1};
    vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         1'b0,1'b1,1'b0,IA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,1'b1,LA,   1'b1,4'hF,1'b0,1'b0,32'h0,         1'b1};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h1234_5678, 1'b0,1'b0,1'b0,LA,   1'b1,4'hF,1'b0,1'b0,32'h0,         1'b1};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,LA,   1'b1,4'hF,1'b0,1'b1,32'h0,         1'b1};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,LA,   1'b1,4'hF,1'b0,1'b0,32'h0,         1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,         1'b0,1'b0,1'b1,IA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b1};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'hCAFE_F00D, 1'b0,1'b0,1'b0,IA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b1};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,IA,   1'b0,4'h0,1'b1,1'b0,32'hCAFE_F00D, 1'b1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h7777_7777, 1'b1,1'b1,1'b0,IA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b0};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b1,1'b0,IA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h1111_1111, 1'b0,1'b0,1'b1,LA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b1};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,         1'b0,1'b0,1'b1,LA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b1};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h55AA_55AA, 1'b0,1'b0,1'b0,LA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b1};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,LA,   1'b0,4'h0,1'b0,1'b1,32'h55AA_55AA, 1'b1};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,LA,   1'b0,4'h0,1'b0,1'b0,32'h0,         1'b0};

    // Reset state of both instances.
    #2;
    chk("reset_a", {ia.ifu_req_ready, ia.lsu_req_ready, ia.mem_req_valid, ia.mem_addr, ia.mem_wen,
                    ia.mem_wdata, ia.mem_wmask, ia.ifu_resp_valid, ia.lsu_resp_valid, ia.busy}, 128'h0);
    chk("reset_b", {ib.ifu_req_ready, ib.lsu_req_ready, ib.mem_req_valid, ib.mem_addr,
                    ib.ifu_resp_valid, ib.lsu_resp_valid, ib.busy}, 128'h0);
    cyc();
    rst = 1'b0;

    // Table-driven cycle vectors on instance A.
    for (int i = 0; i < NV; i++) begin
      ia.ifu_req_valid  = vecs[i].ifu_v;
      ia.lsu_req_valid  = vecs[i].lsu_v;
      ia.lsu_wen        = vecs[i].lsu_wen;
      ia.mem_req_ready  = vecs[i].mrdy;
      ia.mem_resp_valid = vecs[i].mrsp;
      ia.mem_resp_data  = vecs[i].mdata;
      #3;
      chk($sformatf("vec%0d", i),
          {ia.ifu_req_ready, ia.lsu_req_ready, ia.mem_req_valid, ia.mem_addr, ia.mem_wen,
           ia.mem_wmask, ia.ifu_resp_valid, ia.lsu_resp_valid, ia.busy},
          {vecs[i].e_ifu_rdy, vecs[i].e_lsu_rdy, vecs[i].e_mreq, vecs[i].e_addr, vecs[i].e_wen,
           vecs[i].e_wmask, vecs[i].e_ifu_rv, vecs[i].e_lsu_rv, vecs[i].e_busy});
      if (vecs[i].e_ifu_rv)
        chk($sformatf("vec%0d_ifu_data", i), {ia.ifu_resp_err, ia.ifu_resp_data}, {1'b0, vecs[i].e_rdata});
      if (vecs[i].e_lsu_rv)
        chk($sformatf("vec%0d_lsu_data", i), {ia.lsu_resp_err, ia.lsu_resp_data}, {1'b0, vecs[i].e_rdata});
      if (vecs[i].e_mreq && vecs[i].e_wen)
        chk($sformatf("vec%0d_wdata", i), ia.mem_wdata, WD);
      cyc();
    end
    idle_inputs();

    // Backpressure: ready held low 5 cycles, response 3 cycles after ready.
    ia.ifu_addr = 32'h8000_0040;
    ia.ifu_req_valid = 1'b1;
    #3; cyc();
    ia.ifu_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #3; chk($sformatf("bp_hold%0d", k), {ia.mem_req_valid, ia.mem_addr}, {1'b1, 32'h8000_0040});
      cyc();
    end
    ia.mem_req_ready = 1'b1;
    #3; chk("bp_ready", {ia.mem_req_valid, ia.mem_addr}, {1'b1, 32'h8000_0040});
    cyc();
    ia.mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #3; chk($sformatf("bp_wait%0d", k), {ia.mem_req_valid, ia.ifu_resp_valid, ia.busy}, {1'b0, 1'b0, 1'b1});
      cyc();
    end
    ia.mem_resp_valid = 1'b1;
    ia.mem_resp_data  = 32'h0010_0093;
    #3; chk("bp_resp_cycle", {ia.ifu_resp_valid, ia.busy}, {1'b0, 1'b1});
    cyc();
    ia.mem_resp_valid = 1'b0;
    #3; chk("bp_resp", {ia.ifu_resp_valid, ia.ifu_resp_err, ia.ifu_resp_data, ia.lsu_resp_valid},
            {1'b1, 1'b0, 32'h0010_0093, 1'b0});
    cyc();

    // Timeout on instance B (TIMEOUT=4), memory silent.
    ib.ifu_req_valid = 1'b1;
    #3; cyc();
    ib.ifu_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #3; chk($sformatf("to_pending%0d", k), {ib.ifu_resp_valid, ib.mem_req_valid, ib.busy}, {1'b0, 1'b1, 1'b1});
      cyc();
    end
    #3; chk("to_err", {ib.ifu_resp_valid, ib.ifu_resp_err, ib.ifu_resp_data, ib.lsu_resp_valid},
            {1'b1, 1'b1, 32'h0, 1'b0});
    cyc();
    ib.mem_resp_valid = 1'b1;
    ib.mem_resp_data  = 32'h0000_1234;
    #3; chk("to_idle", {ib.busy, ib.ifu_resp_valid}, {1'b0, 1'b0});
    cyc();
    ib.mem_resp_valid = 1'b0;
    #3; chk("to_stray", {ib.ifu_resp_valid, ib.lsu_resp_valid, ib.busy}, 3'b000);
    cyc();

    // Response landing in the timeout cycle wins on instance B.
    ib.lsu_req_valid = 1'b1;
    ib.lsu_wen = 1'b0;
    #3; cyc();
    ib.lsu_req_valid = 1'b0;
    ib.mem_req_ready = 1'b1;
    #3; cyc();
    ib.mem_req_ready = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      #3; chk($sformatf("rat_wait%0d", k), {ib.lsu_resp_valid, ib.busy}, {1'b0, 1'b1});
      cyc();
    end
    ib.mem_resp_valid = 1'b1;
    ib.mem_resp_data  = 32'hABCD_0123;
    #3; chk("rat_hit_cycle", {ib.lsu_resp_valid, ib.busy}, {1'b0, 1'b1});
    cyc();
    ib.mem_resp_valid = 1'b0;
    #3; chk("rat_resp", {ib.lsu_resp_valid, ib.lsu_resp_err, ib.lsu_resp_data, ib.ifu_resp_valid},
            {1'b1, 1'b0, 32'hABCD_0123, 1'b0});
    cyc();

    // Reset while an LSU store waits on instance A.
    ia.lsu_req_valid = 1'b1;
    ia.lsu_wen = 1'b1;
    #3; cyc();
    ia.lsu_req_valid = 1'b0;
    ia.mem_req_ready = 1'b1;
    #3; cyc();
    ia.mem_req_ready = 1'b0;
    #2; chk("rst_pre", {ia.busy, ia.mem_req_valid}, {1'b1, 1'b0});
    rst = 1'b1;
    #1; chk("rst_async", {ia.busy, ia.lsu_resp_valid, ia.ifu_resp_valid, ia.mem_req_valid, ia.lsu_req_ready},
            5'b00000);
    cyc();
    rst = 1'b0;
    ia.mem_resp_valid = 1'b1;
    ia.mem_resp_data  = 32'h9999_9999;
    #3; chk("rst_after", {ia.busy, ia.lsu_resp_valid, ia.ifu_resp_valid, ia.lsu_req_ready}, 4'b0001);
    cyc();
    ia.mem_resp_valid = 1'b0;
    ia.ifu_addr = IA;
    ia.ifu_req_valid = 1'b1;
    #3; chk("rst_reaccept", {ia.ifu_req_ready, ia.lsu_resp_valid, ia.busy}, 3'b100);
    cyc();
    ia.ifu_req_valid = 1'b0;
    ia.mem_req_ready = 1'b1;
    ia.mem_resp_valid = 1'b1;
    ia.mem_resp_data = 32'h0000_0413;
    #3; chk("rst_req", {ia.mem_req_valid, ia.mem_addr, ia.mem_wen, ia.mem_wmask}, {1'b1, IA, 1'b0, 4'h0});
    cyc();
    ia.mem_req_ready = 1'b0;
    ia.mem_resp_valid = 1'b0;
    #3; chk("rst_resp", {ia.ifu_resp_valid, ia.ifu_resp_err, ia.ifu_resp_data, ia.lsu_resp_valid},
            {1'b1, 1'b0, 32'h0000_0413, 1'b0});
    cyc();
    #3; chk("rst_done", {ia.busy, ia.ifu_resp_valid}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
